// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    localparam int          MEM_TIMEOUT_DEF = 15;
    localparam logic [4:0]  REG_ZERO        = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and controller stall/flush outputs.
// Latency: n/a (wires only).
// Backpressure: n/a; master = pipeline datapath, slave = pipeline_ctrl.
// Ports: id_rs1/id_rs2/ex_rd/ex_men2reg/ex_branch_taken/mem_access/dmem_ack
//        flow master->slave; dmem_req/stall_*/bubble_ex/flush_id/hold_mem/
//        mem_timeout/stall_count flow slave->master.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_men2reg;
    logic             ex_branch_taken;
    logic             mem_access;
    logic             dmem_ack;

    logic             dmem_req;
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_id;
    logic             hold_mem;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, ex_rd, ex_men2reg, ex_branch_taken,
               mem_access, dmem_ack,
        input  dmem_req, stall_if, stall_id, bubble_ex, flush_id,
               hold_mem, mem_timeout, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_men2reg, ex_branch_taken,
               mem_access, dmem_ack,
        output dmem_req, stall_if, stall_id, bubble_ex, flush_id,
               hold_mem, mem_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use hazard detector: a load in EX whose destination feeds ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is consumed by the controller priority mux.
// Ports: ex_men2reg, ex_rd, id_rs1, id_rs2 in; load_use out.
module hazard_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic       ex_men2reg,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);
    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_men2reg && (ex_rd != REG_ZERO) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: memory-wait FSM, branch flush, load-use stall, stall counter.
// Latency: stall/flush/bubble/hold are combinational from the same-cycle inputs.
// Backpressure: a memory freeze holds IF/ID and all later stages; branches wait.
// Ports: clk, rst (sync, active-high); bus = pipeline_ctrl_if.slave.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          rst,
    pipeline_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              timeout_flag;
    logic              br_pending;
    logic              lu_stalled;

    logic load_use;
    logic run;
    logic freeze;
    logic branch;
    logic lu_stall;

    hazard_unit u_hazard (
        .ex_men2reg (bus.ex_men2reg),
        .ex_rd      (bus.ex_rd),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .load_use   (load_use)
    );

    // Every combinational output is forced low while reset is asserted.
    assign run    = !rst;
    assign freeze = run && ((bus.mem_access && !bus.dmem_ack) || (state == ST_FAULT));
    // A branch seen while frozen is remembered and applied on the first free cycle.
    assign branch = run && !freeze && (bus.ex_branch_taken || br_pending);
    // The load-use stall lasts one cycle: by then the bubble occupies EX, so a
    // hazard still visible the next cycle is the same one and must not re-stall.
    assign lu_stall = run && !freeze && !branch && load_use && !lu_stalled;

    always_comb begin
        bus.dmem_req  = run && bus.mem_access && (state != ST_FAULT);
        bus.stall_if  = freeze || lu_stall;
        bus.stall_id  = freeze || lu_stall;
        bus.hold_mem  = freeze;
        bus.bubble_ex = branch || lu_stall;
        bus.flush_id  = branch;
    end

    assign bus.mem_timeout = timeout_flag;
    assign bus.stall_count = stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            stall_cnt    <= '0;
            timeout_flag <= 1'b0;
            br_pending   <= 1'b0;
            lu_stalled   <= 1'b0;
        end else begin
            if (bus.stall_if && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            br_pending <= freeze ? (br_pending || bus.ex_branch_taken) : 1'b0;
            lu_stalled <= lu_stall;

            case (state)
                ST_RUN: begin
                    if (bus.mem_access && !bus.dmem_ack) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_ack) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        state        <= ST_FAULT;
                        timeout_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Only reset recovers from a memory timeout.
                    state <= ST_FAULT;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int CNT_W = 4;   // narrow counter so saturation is reachable

    logic clk;
    logic rst;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(
        .MEM_TIMEOUT (15),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    // Output order: dmem_req, stall_if, stall_id, bubble_ex, flush_id, hold_mem
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       men2reg;
        logic       br;
        logic       macc;
        logic       ack;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [5:0] outs();
        return {bus.dmem_req, bus.stall_if, bus.stall_id,
                bus.bubble_ex, bus.flush_id, bus.hold_mem};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic men2reg, input logic br, input logic macc, input logic ack);
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.ex_rd           = rd;
        bus.ex_men2reg      = men2reg;
        bus.ex_branch_taken = br;
        bus.mem_access      = macc;
        bus.dmem_ack        = ack;
    endtask

    task automatic do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        //               rs1    rs2    rd  ld br ma ak  expected
        vecs[0]  = '{5'd0,  5'd0,  5'd0, 0, 0, 0, 0, 6'b000000}; // idle
        vecs[1]  = '{5'd7,  5'd3,  5'd7, 1, 0, 0, 0, 6'b011100}; // load-use on rs1
        vecs[2]  = '{5'd1,  5'd5,  5'd5, 1, 0, 0, 0, 6'b011100}; // load-use on rs2
        vecs[3]  = '{5'd0,  5'd0,  5'd0, 1, 0, 0, 0, 6'b000000}; // x0 never hazards
        vecs[4]  = '{5'd5,  5'd0,  5'd5, 0, 0, 0, 0, 6'b000000}; // not a load
        vecs[5]  = '{5'd4,  5'd6,  5'd5, 1, 0, 0, 0, 6'b000000}; // load, no match
        vecs[6]  = '{5'd0,  5'd0,  5'd0, 0, 1, 0, 0, 6'b000110}; // branch flush
        vecs[7]  = '{5'd9,  5'd0,  5'd9, 1, 1, 0, 0, 6'b000110}; // branch beats load-use
        vecs[8]  = '{5'd0,  5'd0,  5'd0, 0, 0, 1, 1, 6'b100000}; // access acked at once
        vecs[9]  = '{5'd0,  5'd0,  5'd0, 0, 0, 1, 0, 6'b111001}; // access waits: freeze
        vecs[10] = '{5'd9,  5'd0,  5'd9, 1, 1, 1, 0, 6'b111001}; // freeze beats all
        vecs[11] = '{5'd0,  5'd0,  5'd0, 0, 0, 0, 1, 6'b000000}; // stray ack ignored

        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        check("rst_count", 32'(bus.stall_count), 32'd0);
        check("rst_timeout", 32'(bus.mem_timeout), 32'd0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 12; i++) begin
            do_reset();
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].men2reg,
                  vecs[i].br, vecs[i].macc, vecs[i].ack);
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // ---------------- load-use stalls exactly one cycle ----------------
        do_reset();
        drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("lu_first", 32'(outs()), 32'b011100);
        @(posedge clk); #1;
        @(negedge clk);
        check("lu_second", 32'(outs()), 32'b000000);
        check("lu_count", 32'(bus.stall_count), 32'd1);

        // ---------------- memory wait of 3 cycles ----------------
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("mw_hold%0d", c), 32'(outs()), 32'b111001);
            @(posedge clk); #1;
        end
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        check("mw_ack", 32'(outs()), 32'b100000);
        check("mw_count", 32'(bus.stall_count), 32'd3);
        @(posedge clk); #1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("mw_run", 32'(outs()), 32'b100000);
        check("mw_count_after", 32'(bus.stall_count), 32'd3);

        // ---------------- branch deferred across a 2-cycle wait ----------------
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("br_frozen%0d", c), 32'(outs()), 32'b111001);
            @(posedge clk); #1;
        end
        // Branch input deasserted at the release cycle: the flush must come from
        // the remembered request.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("br_release", 32'(outs()), 32'b100110);
        @(posedge clk); #1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("br_pulse_end", 32'(outs()), 32'b000000);

        // ---------------- timeout to FAULT, saturation, reset ----------------
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 15; c++) @(posedge clk);
        @(negedge clk);
        check("to_not_yet", 32'(bus.mem_timeout), 32'd0);
        check("to_sat_count", 32'(bus.stall_count), 32'd15);
        @(posedge clk);
        @(negedge clk);
        check("to_flag", 32'(bus.mem_timeout), 32'd1);
        check("to_fault_outs", 32'(outs()), 32'b011001);
        check("to_count_held", 32'(bus.stall_count), 32'd15);
        @(posedge clk); #1;
        bus.mem_access = 1'b0;
        @(negedge clk);
        check("fault_sticky", 32'(outs()), 32'b011001);
        check("fault_flag_sticky", 32'(bus.mem_timeout), 32'd1);
        @(posedge clk); #1;
        drive(5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_comb_zero", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_clr_count", 32'(bus.stall_count), 32'd0);
        check("rst_clr_flag", 32'(bus.mem_timeout), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_idle", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        bus.mem_access = 1'b1;
        bus.dmem_ack   = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(outs()), 32'b100000);
        check("post_rst_flag", 32'(bus.mem_timeout), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have a parameter MEM_TIMEOUT, default 15, giving the maximum wait cycles for a data-memory ack.
REQ-002 The block SHALL have a parameter CNT_W, default 16, giving the width of the stall counter.
REQ-003 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-007 ex_rd  in  5  destination register of the instruction in EX.
REQ-008 ex_men2reg  in  1  instruction in EX is a load.
REQ-009 ex_branch_taken  in  1  branch/jump in EX resolved taken.
REQ-010 mem_access  in  1  instruction in MEM is a load or store.
REQ-011 dmem_ack  in  1  data memory completes the current access.
REQ-012 dmem_req  out  1  data-memory request.
REQ-013 stall_if, stall_id  out  1 each  hold the PC and IF/ID registers.
REQ-014 bubble_ex  out  1  load a NOP into ID/EX (reg_write=0, men2reg=0).
REQ-015 flush_id  out  1  clear the IF/ID register.
REQ-016 hold_mem  out  1  freeze ID/EX, EX/MEM and MEM/WB.
REQ-017 mem_timeout  out  1  sticky error flag.
REQ-018 stall_count  out  CNT_W  saturating count of stall cycles.

Function
REQ-019 The FSM SHALL have states RUN, MEM_WAIT and FAULT.
REQ-020 dmem_req SHALL be driven as mem_access AND (state != FAULT), combinationally.
REQ-021 In RUN, if mem_access=1 and dmem_ack=0, the next state SHALL be MEM_WAIT and the wait counter SHALL be loaded with 1.
REQ-022 In RUN, if mem_access=1 and dmem_ack=1, the block SHALL stay in RUN with no stall.
REQ-023 In MEM_WAIT, dmem_ack=1 SHALL return the FSM to RUN on the next edge.
REQ-024 In MEM_WAIT, with dmem_ack=0, the wait counter SHALL increment each cycle.
REQ-025 In MEM_WAIT, with dmem_ack=0 and the wait counter equal to MEM_TIMEOUT, the FSM SHALL go to FAULT.
REQ-026 A memory freeze SHALL be defined as (mem_access AND NOT dmem_ack) OR state==FAULT.
REQ-027 During a memory freeze, stall_if, stall_id and hold_mem SHALL be 1, and bubble_ex and flush_id SHALL be 0.
REQ-028 During a memory freeze, a pending ex_branch_taken SHALL be deferred until the freeze releases, not dropped.
REQ-029 If there is no freeze and ex_branch_taken=1, flush_id and bubble_ex SHALL be 1 and stall_if and stall_id SHALL be 0; this overrides load-use.
REQ-030 A load-use hazard SHALL be defined as ex_men2reg AND ex_rd!=0 AND (ex_rd==id_rs1 OR ex_rd==id_rs2).
REQ-031 If there is no freeze, no branch and a load-use hazard, stall_if, stall_id and bubble_ex SHALL be 1 for exactly one cycle.
REQ-032 Register x0 SHALL never cause a load-use hazard.
REQ-033 stall_count SHALL increment on every cycle with stall_if=1 and SHALL saturate at all-ones.
REQ-034 mem_timeout SHALL be set on entry to FAULT and held until rst.
REQ-035 FAULT SHALL be left only by rst.

Reset
REQ-036 On rst=1 at a rising edge, state SHALL be RUN, the wait counter 0, stall_count 0 and mem_timeout 0.
REQ-037 During rst, all combinational outputs SHALL be 0, including dmem_req.
REQ-038 A reset in MEM_WAIT or FAULT SHALL abandon the outstanding access with no further dmem_req until mem_access is reasserted after reset.

Structure
REQ-039 The package pipeline_ctrl_pkg SHALL hold the state enum, the MEM_TIMEOUT default and the REG_ZERO constant (5'd0).
REQ-040 Load-use detection SHALL be a combinational sub-module hazard_unit; the FSM, counters and priority mux SHALL stay in pipeline_ctrl.

Verification
REQ-041 The bench SHALL drive ex_men2reg=1, ex_rd=5, id_rs2=5 and check one cycle of stall_if=stall_id=bubble_ex=1, with stall_count=1 afterwards.
REQ-042 The bench SHALL drive ex_men2reg=1, ex_rd=0, id_rs1=0 and check that no stall occurs.
REQ-043 The bench SHALL drive a load-use hazard together with ex_branch_taken=1 and check flush_id=bubble_ex=1 and stall_if=0.
REQ-044 The bench SHALL drive mem_access=1 with dmem_ack arriving after 3 cycles and check hold_mem=1 for 3 cycles, the return to RUN, and stall_count=3.
REQ-045 The bench SHALL drive mem_access=1 with no ack and check FAULT and mem_timeout=1 after 15 wait cycles; rst SHALL then clear every output to 0.
REQ-046 The bench SHALL drive ex_branch_taken=1 during a 2-cycle memory wait and check that flush_id pulses on the first cycle after the ack.
